refclk_freq_monitor: RTL and testbench

//  Checks the SERDES external reference clock after the EXTREF pad buffer, before the PCS/PLL is released.

---
 rtl/refclk_freq_monitor.sv | 144 ++++++++++++++
 tb/tb_refclk_freq_monitor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/refclk_freq_monitor.sv
// Reference clock frequency monitor: counts edges of a divided refclk toggle
// over a fixed window of system clocks and qualifies the refclk after a run
// of consecutive in-range windows.
module refclk_freq_monitor #(
  parameter int unsigned WINDOW       = 1024,
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned MIN_CNT      = 480,
  parameter int unsigned MAX_CNT      = 544,
  parameter int unsigned GOOD_WINDOWS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             REFTGL,
  output logic             REFCLK_OK,
  output logic             LOSS,
  output logic             CNT_VALID,
  output logic [CNT_W-1:0] LAST_CNT
);

  localparam int unsigned WC_W = $clog2(WINDOW);
  localparam int unsigned GC_W = $clog2(GOOD_WINDOWS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    UP   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              s1, s2, s3;
  logic              tgl_edge;
  logic [WC_W-1:0]   wc;
  logic [CNT_W-1:0]  ec;
  logic [CNT_W-1:0]  ec_plus;
  logic [GC_W-1:0]   gc, gc_nxt;
  logic              tc;
  logic              good;
  logic              ok_nxt;
  logic              loss_nxt;
  logic              valid_nxt;

  assign tgl_edge = s2 ^ s3;
  assign tc       = (state != IDLE) && (wc == WC_W'(WINDOW - 1));
  // Saturating add: a too-fast refclk must never wrap back into range.
  assign ec_plus  = (ec == '1) ? ec : ec + CNT_W'(tgl_edge);
  assign good     = (32'(ec_plus) >= MIN_CNT) && (32'(ec_plus) <= MAX_CNT);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and registered-output decode; EN=0 overrides a coincident TC.
  always_comb begin
    state_nxt = state;
    gc_nxt    = gc;
    ok_nxt    = REFCLK_OK;
    loss_nxt  = 1'b0;
    valid_nxt = 1'b0;
    if (!EN) begin
      state_nxt = IDLE;
      gc_nxt    = '0;
      ok_nxt    = 1'b0;
      loss_nxt  = (state == UP);
    end else begin
      case (state)
        IDLE: begin
          state_nxt = QUAL;
          gc_nxt    = '0;
        end
        QUAL: begin
          if (tc) begin
            valid_nxt = 1'b1;
            if (good) begin
              if (gc == GC_W'(GOOD_WINDOWS - 1)) begin
                state_nxt = UP;
                ok_nxt    = 1'b1;
                gc_nxt    = '0;
              end else begin
                gc_nxt = gc + GC_W'(1);
              end
            end else begin
              gc_nxt = '0;
            end
          end
        end
        UP: begin
          if (tc) begin
            valid_nxt = 1'b1;
            if (!good) begin
              state_nxt = QUAL;
              gc_nxt    = '0;
              ok_nxt    = 1'b0;
              loss_nxt  = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          gc_nxt    = '0;
          ok_nxt    = 1'b0;
        end
      endcase
    end
  end

  // Synchronizer, window/edge counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      wc        <= '0;
      ec        <= '0;
      gc        <= '0;
      REFCLK_OK <= 1'b0;
      LOSS      <= 1'b0;
      CNT_VALID <= 1'b0;
      LAST_CNT  <= '0;
    end else begin
      s1        <= REFTGL;
      s2        <= s1;
      s3        <= s2;
      gc        <= gc_nxt;
      REFCLK_OK <= ok_nxt;
      LOSS      <= loss_nxt;
      CNT_VALID <= valid_nxt;
      if (!EN || state == IDLE) begin
        wc <= '0;
        ec <= '0;
      end else if (tc) begin
        wc       <= '0;
        ec       <= '0;
        LAST_CNT <= ec_plus;
      end else begin
        wc <= wc + WC_W'(1);
        ec <= ec_plus;
      end
    end
  end

endmodule

// File: tb/tb_refclk_freq_monitor.sv
// Self-checking bench for refclk_freq_monitor: directed scenarios plus a
// randomized phase, checked every cycle against a window-level model.
module tb_refclk_freq_monitor;

  localparam int WIN  = 64;
  localparam int MINC = 14;
  localparam int MAXC = 18;
  localparam int GW   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       reftgl = 1'b0;
  logic       ok, loss, valid;
  logic [7:0] last;
  logic       sat_ok, sat_loss, sat_valid;
  logic [4:0] sat_last;

  int n_checks = 0;
  int n_fail   = 0;
  int period   = 0;  // >0: toggle every period CLK; 0: stuck; <0: random level

  refclk_freq_monitor #(.WINDOW(WIN), .CNT_W(8), .MIN_CNT(MINC), .MAX_CNT(MAXC),
                        .GOOD_WINDOWS(GW)) dut (
    .CLK(clk), .RST(rst), .EN(en), .REFTGL(reftgl),
    .REFCLK_OK(ok), .LOSS(loss), .CNT_VALID(valid), .LAST_CNT(last));

  // Narrow counter instance so that saturation is reachable within one window.
  refclk_freq_monitor #(.WINDOW(WIN), .CNT_W(5), .MIN_CNT(MINC), .MAX_CNT(MAXC),
                        .GOOD_WINDOWS(GW)) u_sat (
    .CLK(clk), .RST(rst), .EN(en), .REFTGL(reftgl),
    .REFCLK_OK(sat_ok), .LOSS(sat_loss), .CNT_VALID(sat_valid), .LAST_CNT(sat_last));

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Refclk toggle generator.
  initial begin
    int pc;
    pc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (period > 0) begin
        pc++;
        if (pc >= period) begin
          reftgl = ~reftgl;
          pc = 0;
        end
      end else if (period < 0) begin
        reftgl = 1'($urandom_range(0, 1));
      end
    end
  end

  // Window-level model: records the level seen at each edge and, when a window
  // closes, counts level changes seen through the 3-cycle synchronizer delay.
  bit samp [0:65535];
  int e = 10;
  bit model_live = 0;
  bit m_idle = 1;
  int m_close = 0;
  int m_streak = 0;
  bit m_ok = 0, m_loss = 0, m_valid = 0;
  int m_raw = 0;

  initial begin
    int n;
    forever begin
      @(posedge clk);
      e++;
      m_loss  = 0;
      m_valid = 0;
      if (rst) begin
        samp[e] = 0; samp[e-1] = 0; samp[e-2] = 0;
        m_idle = 1; m_streak = 0; m_ok = 0; m_raw = 0;
        model_live = 1;
      end else begin
        samp[e] = reftgl;
        if (!en) begin
          if (m_ok) m_loss = 1;
          m_ok = 0; m_streak = 0; m_idle = 1;
        end else if (m_idle) begin
          m_idle = 0;
          m_close = e + WIN;
        end else if (e == m_close) begin
          n = 0;
          for (int m = e - WIN + 1; m <= e; m++) n += int'(samp[m-2] ^ samp[m-3]);
          m_raw = n;
          m_valid = 1;
          if (n >= MINC && n <= MAXC) m_streak++;
          else m_streak = 0;
          if (m_streak >= GW) m_ok = 1;
          else begin
            if (m_ok) m_loss = 1;
            m_ok = 0;
          end
          m_close += WIN;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (model_live) begin
      check("ok", ok, m_ok);
      check("loss", loss, m_loss);
      check("valid", valid, m_valid);
      check("last", last, (m_raw > 255) ? 255 : m_raw);
      check("sat_ok", sat_ok, m_ok);
      check("sat_loss", sat_loss, m_loss);
      check("sat_valid", sat_valid, m_valid);
      check("sat_last", sat_last, (m_raw > 31) ? 31 : m_raw);
    end
  end

  initial begin
    int waited;
    int r;
    // Reset state
    tick(3);
    rst = 0;
    tick(2);
    check("rst_ok", ok, 0);
    check("rst_loss", loss, 0);
    check("rst_valid", valid, 0);
    check("rst_last", last, 0);

    // 1: toggle every 4 CLK -> 16 edges per window, qualified after 3rd TC
    period = 4;
    tick(5);
    en = 1;
    tick(1);
    tick(191);
    check("s1_ok_early", ok, 0);
    tick(1);
    check("s1_ok_rise", ok, 1);
    check("s1_last", last, 16);
    check("s1_valid", valid, 1);

    // 2: refclk stops at a window boundary -> loss at the next TC
    period = 0;
    waited = 0;
    while (!loss && waited < 200) begin
      tick(1);
      waited++;
    end
    check("s2_loss_delay", waited, 64);
    check("s2_last_small", (last <= 8'd1), 1);
    check("s2_ok_fall", ok, 0);
    tick(1);
    check("s2_loss_pulse", loss, 0);

    // 3: too fast, then far too fast (saturation on narrow instance)
    period = 2;
    tick(4 * WIN);
    check("s3_ok_fast", ok, 0);
    period = 1;
    tick(2 * WIN + 5);
    check("s3_last64", last, 64);
    check("s3_sat_last", sat_last, 31);
    check("s3_ok_vfast", ok, 0);

    // 4: good, good, bad, good x3 -> qualified only at 6th TC
    en = 0;
    period = 4;
    tick(8);
    en = 1;
    tick(1);
    tick(125);
    period = 2;
    tick(64);
    period = 4;
    tick(4);
    check("s4_ok_after3", ok, 0);
    tick(190);
    check("s4_ok_early", ok, 0);
    tick(1);
    check("s4_ok_rise", ok, 1);

    // 5: EN dropped while UP, then requalification
    tick(20);
    en = 0;
    tick(1);
    check("s5_ok", ok, 0);
    check("s5_loss", loss, 1);
    check("s5_valid", valid, 0);
    tick(1);
    check("s5_loss_end", loss, 0);
    en = 1;
    tick(1);
    tick(191);
    check("s5_ok_early", ok, 0);
    tick(1);
    check("s5_ok_rise", ok, 1);

    // 6: RST mid-window while UP, then RST coincident with TC
    tick(30);
    rst = 1;
    tick(1);
    check("s6_ok", ok, 0);
    check("s6_loss", loss, 0);
    check("s6_valid", valid, 0);
    check("s6_last", last, 0);
    rst = 0;
    tick(1);
    tick(191);
    check("s6_ok_early", ok, 0);
    tick(1);
    check("s6_ok_rise", ok, 1);
    tick(63);
    rst = 1;
    tick(1);
    check("s6tc_ok", ok, 0);
    check("s6tc_loss", loss, 0);
    check("s6tc_valid", valid, 0);
    check("s6tc_last", last, 0);
    rst = 0;

    // Randomized phase
    for (int s = 0; s < 40; s++) begin
      r = int'($urandom_range(0, 11));
      case (r)
        0: period = 0;
        1: period = 1;
        2: period = 2;
        3: period = -1;
        4: period = 3;
        5: period = 5;
        default: period = 4;
      endcase
      tick(int'($urandom_range(20, 400)));
      if ($urandom_range(0, 9) == 0) begin
        en = 0;
        tick(int'($urandom_range(1, 5)));
        en = 1;
      end
      if ($urandom_range(0, 19) == 0) begin
        rst = 1;
        tick(1);
        rst = 0;
      end
    end
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
